// File: rtl/pcie_msi_intr_controller.sv
// rtl/pcie_msi_intr_controller.sv - PCIe INTx/MSI interrupt controller with ASHI register access
// Per-source edge/level detection, saturating event counters, round-robin MSI arbitration with holdoff.
module pcie_msi_intr_controller #(
  parameter int IRQ_COUNT    = 8,
  parameter int VECTOR_COUNT = 4,
  parameter int CNT_WIDTH    = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IRQ_COUNT-1:0] IRQ_IN,
  input  logic                 MSI_ENABLE,
  output logic                 IRQ_REQ,
  output logic [4:0]           IRQ_VECTOR,
  input  logic                 IRQ_ACK,
  input  logic [31:0]          ASHI_WINDX,
  input  logic [31:0]          ASHI_WDATA,
  input  logic                 ASHI_WRITE,
  output logic [1:0]           ASHI_WRESP,
  input  logic [31:0]          ASHI_RINDX,
  input  logic                 ASHI_READ,
  output logic [31:0]          ASHI_RDATA,
  output logic [1:0]           ASHI_RRESP
);

  localparam int IDXW = (IRQ_COUNT > 1) ? $clog2(IRQ_COUNT) : 1;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  // Saturate one below all-ones so counter+event on a read still fits the width.
  localparam logic [CNT_WIDTH-1:0] CNT_SAT = {{(CNT_WIDTH-1){1'b1}}, 1'b0};
  localparam logic [4:0] VEC_MASK = 5'(VECTOR_COUNT - 1);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LEG_WAIT,
    ST_MSI_REQ,
    ST_MSI_HOLD
  } state_t;

  logic [IRQ_COUNT-1:0] irq_sync_q, irq_prev_q;
  logic [IRQ_COUNT-1:0] mask_q, mode_q, sent_q, sent_d;
  logic                 global_q;
  logic [15:0]          holdoff_q;
  logic [CNT_WIDTH-1:0] cnt_q [IRQ_COUNT];
  logic [CNT_WIDTH-1:0] cnt_d [IRQ_COUNT];

  state_t               state_q, state_d;
  logic                 req_q, req_d;
  logic [4:0]           vec_q, vec_d;
  logic [IDXW-1:0]      sel_q, sel_d, last_q, last_d;
  logic [15:0]          timer_q, timer_d;
  logic                 msi_ack;

  logic [31:0]          rdata_q, rdata_d;
  logic [1:0]           rresp_q, rresp_d, wresp_q;

  logic wr_pend, wr_ack, wr_mask, wr_glob, wr_mode, wr_hold, wr_known;
  logic [31:0]          rindx_off;
  logic                 rd_cnt_hit;
  logic [IDXW-1:0]      rd_cnt_idx;
  logic [CNT_WIDTH-1:0] cnt_rd;
  logic [IRQ_COUNT-1:0] rise, sw_trig, evt, clr, clr_rd, pending, cand;
  logic                 intx_want;
  logic                 found_hi, found_any;
  logic [IDXW-1:0]      pick_hi, pick_lo, pick;
  logic                 unused_ok;

  assign wr_pend  = ASHI_WRITE && (ASHI_WINDX == 32'd0);
  assign wr_ack   = ASHI_WRITE && (ASHI_WINDX == 32'd1);
  assign wr_mask  = ASHI_WRITE && (ASHI_WINDX == 32'd2);
  assign wr_glob  = ASHI_WRITE && (ASHI_WINDX == 32'd3);
  assign wr_mode  = ASHI_WRITE && (ASHI_WINDX == 32'd4);
  assign wr_hold  = ASHI_WRITE && (ASHI_WINDX == 32'd5);
  assign wr_known = (ASHI_WINDX < 32'd6);

  assign rindx_off  = ASHI_RINDX - 32'd32;
  assign rd_cnt_hit = ASHI_READ && (ASHI_RINDX >= 32'd32) && (rindx_off < 32'(IRQ_COUNT));
  assign rd_cnt_idx = rindx_off[IDXW-1:0];
  assign unused_ok  = ^{ASHI_WDATA, rindx_off};

  assign rise    = irq_sync_q & ~irq_prev_q;
  assign sw_trig = wr_pend ? ASHI_WDATA[IRQ_COUNT-1:0] : '0;
  assign evt     = (rise | sw_trig) & mask_q;
  assign clr     = (wr_ack ? ASHI_WDATA[IRQ_COUNT-1:0] : '0) | clr_rd;

  always_comb begin
    clr_rd  = '0;
    pending = '0;
    for (int i = 0; i < IRQ_COUNT; i++) begin
      clr_rd[i]  = rd_cnt_hit && (rd_cnt_idx == IDXW'(i));
      pending[i] = (cnt_q[i] != '0) | (~mode_q[i] & irq_sync_q[i] & mask_q[i]);
    end
  end

  // A clear coinciding with an event reloads the counter with that event.
  always_comb begin
    for (int i = 0; i < IRQ_COUNT; i++) begin
      cnt_d[i] = cnt_q[i];
      if (clr[i]) begin
        cnt_d[i] = CNT_WIDTH'(evt[i]);
      end else if (evt[i] && (cnt_q[i] != CNT_SAT)) begin
        cnt_d[i] = cnt_q[i] + CNT_WIDTH'(1);
      end
    end
  end

  always_comb begin
    sent_d = sent_q & ~clr;
    if (msi_ack) begin
      sent_d[sel_q] = 1'b1;
    end
  end

  assign cnt_rd = cnt_q[rd_cnt_idx] + CNT_WIDTH'(evt[rd_cnt_idx]);

  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_OKAY;
    case (ASHI_RINDX)
      32'd0, 32'd1: rdata_d = 32'(pending);
      32'd2:        rdata_d = 32'(mask_q);
      32'd3:        rdata_d = {31'd0, global_q};
      32'd4:        rdata_d = 32'(mode_q);
      32'd5:        rdata_d = {16'd0, holdoff_q};
      default: begin
        if (rd_cnt_hit) begin
          rdata_d = 32'(cnt_rd);
        end else begin
          rresp_d = RESP_SLVERR;
        end
      end
    endcase
  end

  assign intx_want = (|pending) & global_q;
  assign cand      = pending & ~sent_q & {IRQ_COUNT{global_q}};

  // Descending scan: the lowest candidate above last_q wins, else the lowest overall.
  always_comb begin
    found_hi  = 1'b0;
    found_any = 1'b0;
    pick_hi   = '0;
    pick_lo   = '0;
    for (int i = IRQ_COUNT - 1; i >= 0; i--) begin
      if (cand[i]) begin
        found_any = 1'b1;
        pick_lo   = IDXW'(i);
        if (IDXW'(i) > last_q) begin
          found_hi = 1'b1;
          pick_hi  = IDXW'(i);
        end
      end
    end
    pick = found_hi ? pick_hi : pick_lo;
  end

  always_comb begin
    state_d = state_q;
    req_d   = req_q;
    vec_d   = vec_q;
    sel_d   = sel_q;
    last_d  = last_q;
    timer_d = timer_q;
    msi_ack = 1'b0;
    case (state_q)
      ST_IDLE: begin
        // IRQ_REQ high in IDLE can only be a legacy level; lower it via a handshake first.
        if (req_q) begin
          if (MSI_ENABLE || !intx_want) begin
            req_d   = 1'b0;
            state_d = ST_LEG_WAIT;
          end
        end else if (MSI_ENABLE) begin
          if (found_any) begin
            req_d   = 1'b1;
            sel_d   = pick;
            vec_d   = 5'(pick) & VEC_MASK;
            state_d = ST_MSI_REQ;
          end
        end else if (intx_want) begin
          req_d   = 1'b1;
          state_d = ST_LEG_WAIT;
        end
      end
      ST_LEG_WAIT: begin
        if (IRQ_ACK) begin
          state_d = ST_IDLE;
        end
      end
      ST_MSI_REQ: begin
        if (IRQ_ACK) begin
          msi_ack = 1'b1;
          req_d   = 1'b0;
          last_d  = sel_q;
          timer_d = holdoff_q;
          state_d = ST_MSI_HOLD;
        end
      end
      ST_MSI_HOLD: begin
        if (timer_q <= 16'd1) begin
          timer_d = 16'd0;
          state_d = ST_IDLE;
        end else begin
          timer_d = timer_q - 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= ST_IDLE;
      req_q   <= 1'b0;
      vec_q   <= '0;
      sel_q   <= '0;
      last_q  <= IDXW'(IRQ_COUNT - 1);
      timer_q <= '0;
      sent_q  <= '0;
    end else begin
      state_q <= state_d;
      req_q   <= req_d;
      vec_q   <= vec_d;
      sel_q   <= sel_d;
      last_q  <= last_d;
      timer_q <= timer_d;
      sent_q  <= sent_d;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      irq_sync_q <= '0;
      irq_prev_q <= '0;
      for (int i = 0; i < IRQ_COUNT; i++) begin
        cnt_q[i] <= '0;
      end
    end else begin
      irq_sync_q <= IRQ_IN;
      irq_prev_q <= irq_sync_q;
      for (int i = 0; i < IRQ_COUNT; i++) begin
        cnt_q[i] <= cnt_d[i];
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mask_q    <= '0;
      mode_q    <= '0;
      global_q  <= 1'b0;
      holdoff_q <= '0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
      wresp_q   <= RESP_OKAY;
    end else begin
      if (wr_mask) mask_q    <= ASHI_WDATA[IRQ_COUNT-1:0];
      if (wr_mode) mode_q    <= ASHI_WDATA[IRQ_COUNT-1:0];
      if (wr_glob) global_q  <= ASHI_WDATA[0];
      if (wr_hold) holdoff_q <= ASHI_WDATA[15:0];
      if (ASHI_WRITE) begin
        wresp_q <= wr_known ? RESP_OKAY : RESP_SLVERR;
      end
      if (ASHI_READ) begin
        rdata_q <= rdata_d;
        rresp_q <= rresp_d;
      end
    end
  end

  assign IRQ_REQ    = req_q;
  assign IRQ_VECTOR = vec_q;
  assign ASHI_RDATA = rdata_q;
  assign ASHI_RRESP = rresp_q;
  assign ASHI_WRESP = wresp_q;

endmodule

// File: tb/tb_pcie_msi_intr_controller.sv
// tb/tb_pcie_msi_intr_controller.sv - directed self-checking bench for pcie_msi_intr_controller
module tb_pcie_msi_intr_controller;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  irq_in = '0;
  logic        msi_en = 1'b0;
  logic        irq_req;
  logic [4:0]  irq_vec;
  logic        irq_ack = 1'b0;
  logic [31:0] windx = '0, wdata = '0, rindx = '0;
  logic        wr = 1'b0, rd = 1'b0;
  logic [1:0]  wresp, rresp;
  logic [31:0] rdata;

  int checks = 0;
  int failures = 0;
  logic [31:0] d;
  logic [1:0]  r;
  int gap;

  always #5 clk = ~clk;

  pcie_msi_intr_controller #(
    .IRQ_COUNT(8), .VECTOR_COUNT(4), .CNT_WIDTH(8)
  ) dut (
    .clk(clk), .reset(reset), .IRQ_IN(irq_in), .MSI_ENABLE(msi_en),
    .IRQ_REQ(irq_req), .IRQ_VECTOR(irq_vec), .IRQ_ACK(irq_ack),
    .ASHI_WINDX(windx), .ASHI_WDATA(wdata), .ASHI_WRITE(wr), .ASHI_WRESP(wresp),
    .ASHI_RINDX(rindx), .ASHI_READ(rd), .ASHI_RDATA(rdata), .ASHI_RRESP(rresp)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic reg_wr(input logic [31:0] idx, input logic [31:0] data);
    windx = idx; wdata = data; wr = 1'b1;
    tick;
    wr = 1'b0;
  endtask

  task automatic reg_rd(input logic [31:0] idx, output logic [31:0] data, output logic [1:0] resp);
    rindx = idx; rd = 1'b1;
    tick;
    rd = 1'b0;
    data = rdata;
    resp = rresp;
  endtask

  task automatic wait_req(input logic lvl, input int budget, input string tag);
    int n = 0;
    while (irq_req !== lvl && n < budget) begin
      tick;
      n++;
    end
    check_eq(tag, 32'(irq_req), 32'(lvl));
  endtask

  task automatic pulse_ack;
    irq_ack = 1'b1;
    tick;
    irq_ack = 1'b0;
  endtask

  task automatic do_reset;
    #2 reset = 1'b1;
    msi_en = 1'b0;
    irq_in = '0;
    repeat (2) tick;
    reset = 1'b0;
    tick;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    do_reset;
    check_eq("rst_req", 32'(irq_req), 0);
    check_eq("rst_vec", 32'(irq_vec), 0);
    check_eq("rst_rdata", rdata, 0);
    check_eq("rst_rresp", 32'(rresp), 0);
    check_eq("rst_wresp", 32'(wresp), 0);

    // Legacy INTx
    reg_wr(2, 1); reg_wr(3, 1); reg_wr(4, 1);
    for (int k = 0; k < 3; k++) begin
      irq_in[0] = 1'b1; tick;
      irq_in[0] = 1'b0; tick;
    end
    repeat (2) tick;
    wait_req(1'b1, 10, "leg_req_rise");
    pulse_ack;
    reg_rd(0, d, r);
    check_eq("leg_pending", d, 32'h1);
    check_eq("leg_req_hold", 32'(irq_req), 1);
    reg_rd(32, d, r);
    check_eq("leg_cnt_read", d, 3);
    check_eq("leg_cnt_resp", 32'(r), 0);
    wait_req(1'b0, 5, "leg_req_fall");
    irq_in[0] = 1'b1; tick; irq_in[0] = 1'b0;
    repeat (5) tick;
    check_eq("leg_wait_ack", 32'(irq_req), 0);
    pulse_ack;
    wait_req(1'b1, 5, "leg_rerise");

    // MSI arbitration
    do_reset;
    msi_en = 1'b1;
    reg_wr(2, 32'hFF); reg_wr(4, 32'hFF); reg_wr(3, 1);
    irq_in = 8'h22; tick; irq_in = '0;
    wait_req(1'b1, 10, "msi1_req");
    check_eq("msi1_vec", 32'(irq_vec), 1);
    repeat (5) tick;
    check_eq("msi1_hold", 32'(irq_req), 1);
    pulse_ack;
    check_eq("msi1_drop", 32'(irq_req), 0);
    wait_req(1'b1, 10, "msi2_req");
    check_eq("msi2_vec", 32'(irq_vec), 1);
    pulse_ack;
    repeat (10) tick;
    check_eq("msi_no_third", 32'(irq_req), 0);
    irq_in = 8'h48; tick; irq_in = '0;
    wait_req(1'b1, 10, "rr_first_req");
    check_eq("rr_first_vec", 32'(irq_vec), 2);
    pulse_ack;
    wait_req(1'b1, 10, "rr_second_req");
    check_eq("rr_second_vec", 32'(irq_vec), 3);
    pulse_ack;
    reg_wr(1, 32'h2);
    reg_wr(0, 32'h2);
    wait_req(1'b1, 10, "msi_after_clear");
    check_eq("msi_after_clear_vec", 32'(irq_vec), 1);
    pulse_ack;

    // Coalescing holdoff
    do_reset;
    msi_en = 1'b1;
    reg_wr(2, 32'hFF); reg_wr(3, 1); reg_wr(5, 100);
    reg_wr(0, 32'h5);
    wait_req(1'b1, 10, "hold_first_req");
    check_eq("hold_first_vec", 32'(irq_vec), 0);
    irq_ack = 1'b1; tick; irq_ack = 1'b0;
    gap = 0;
    while (irq_req !== 1'b1 && gap < 200) begin
      tick;
      gap++;
    end
    check_eq("holdoff_gap", 32'(gap), 101);
    check_eq("hold_second_vec", 32'(irq_vec), 2);
    pulse_ack;

    // Level mode
    do_reset;
    msi_en = 1'b1;
    reg_wr(2, 32'hFF); reg_wr(3, 1);
    irq_in[2] = 1'b1;
    wait_req(1'b1, 10, "lvl_req");
    check_eq("lvl_vec", 32'(irq_vec), 2);
    pulse_ack;
    tick;
    reg_rd(34, d, r);
    check_eq("lvl_cnt_read", d, 1);
    reg_rd(0, d, r);
    check_eq("lvl_pending", d, 32'h4);
    wait_req(1'b1, 10, "lvl_new_msi");
    check_eq("lvl_new_vec", 32'(irq_vec), 2);
    pulse_ack;
    irq_in[2] = 1'b0;
    repeat (3) tick;
    reg_rd(0, d, r);
    check_eq("lvl_pending_clear", d, 0);

    // Boundaries
    do_reset;
    reg_wr(2, 32'hFF); reg_wr(4, 32'hFF);
    reg_wr(0, 1); reg_wr(0, 1);
    irq_in[0] = 1'b1; tick;
    reg_wr(1, 1);
    irq_in[0] = 1'b0;
    check_eq("ack_wresp", 32'(wresp), 0);
    reg_rd(32, d, r);
    check_eq("clr_evt_same_cycle", d, 1);
    for (int k = 0; k < 256; k++) reg_wr(0, 32'h8);
    reg_rd(35, d, r);
    check_eq("cnt_saturate", d, 254);
    reg_rd(40, d, r);
    check_eq("bad_idx_data", d, 0);
    check_eq("bad_idx_resp", 32'(r), 2);
    reg_rd(6, d, r);
    check_eq("idx6_resp", 32'(r), 2);
    reg_wr(32, 5);
    check_eq("cnt_write_resp", 32'(wresp), 2);

    // Reset during MSI REQ
    do_reset;
    msi_en = 1'b1;
    reg_wr(2, 32'hFF); reg_wr(3, 1); reg_wr(4, 32'hFF); reg_wr(5, 7);
    reg_wr(0, 1);
    wait_req(1'b1, 10, "rst_mid_req");
    #2 reset = 1'b1;
    #1;
    check_eq("rst_async_req", 32'(irq_req), 0);
    repeat (2) tick;
    reset = 1'b0;
    tick;
    reg_rd(2, d, r); check_eq("rst_mask", d, 0);
    reg_rd(3, d, r); check_eq("rst_global", d, 0);
    reg_rd(4, d, r); check_eq("rst_mode", d, 0);
    reg_rd(5, d, r); check_eq("rst_holdoff", d, 0);
    reg_rd(0, d, r); check_eq("rst_pending", d, 0);
    reg_rd(32, d, r); check_eq("rst_counter", d, 0);
    check_eq("rst_req_after", 32'(irq_req), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
